// File: rtl/traffic_phase_ctrl_if.sv
// Control inputs and display/LED outputs of the traffic phase sequencer.
// master drives the controls; slave is the sequencer itself.
interface traffic_phase_ctrl_if;
    logic       i_en;
    logic       i_ped_req;
    logic       i_night;
    logic [1:0] o_phase;
    logic [3:0] o_tens;
    logic [3:0] o_ones;
    logic       o_ped_ack;
    logic       o_phase_start;

    modport master (
        output i_en, i_ped_req, i_night,
        input  o_phase, o_tens, o_ones, o_ped_ack, o_phase_start
    );

    modport slave (
        input  i_en, i_ped_req, i_night,
        output o_phase, o_tens, o_ones, o_ped_ack, o_phase_start
    );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// RED/GREEN/YELLOW phase sequencer with BCD countdown, pedestrian
// green shortening, pause and night flash mode.
module traffic_phase_ctrl #(
    parameter int T_RED    = 25,
    parameter int T_GREEN  = 30,
    parameter int T_YELLOW = 5,
    parameter int T_PED    = 5
) (
    input  logic                 clk_1Hz,
    input  logic                 i_rst_n,
    traffic_phase_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_RED       = 3'd0,
        S_GREEN     = 3'd1,
        S_YELLOW    = 3'd2,
        S_NIGHT_ON  = 3'd3,
        S_NIGHT_OFF = 3'd4
    } state_t;

    localparam logic [6:0] L_RED    = 7'(T_RED);
    localparam logic [6:0] L_GREEN  = 7'(T_GREEN);
    localparam logic [6:0] L_YELLOW = 7'(T_YELLOW);
    localparam logic [6:0] L_PED    = 7'(T_PED);
    localparam logic [3:0] RST_TENS = 4'(T_RED / 10);
    localparam logic [3:0] RST_ONES = 4'(T_RED % 10);

    state_t     state_q, state_d;
    state_t     nxt_state;
    logic [6:0] nxt_len;
    logic [6:0] rem_q, rem_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [1:0] phase_q, phase_d;
    logic       ped_q, ped_d;
    logic       ack_q, ack_d;
    logic       start_q, start_d;

    always_ff @(posedge clk_1Hz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_RED;
            rem_q   <= L_RED;
            tens_q  <= RST_TENS;
            ones_q  <= RST_ONES;
            phase_q <= 2'b01;
            ped_q   <= 1'b0;
            ack_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            phase_q <= phase_d;
            ped_q   <= ped_d;
            ack_q   <= ack_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        nxt_state = S_RED;
        nxt_len   = L_RED;
        unique case (state_q)
            S_RED: begin
                nxt_state = S_GREEN;
                nxt_len   = L_GREEN;
            end
            S_GREEN: begin
                nxt_state = S_YELLOW;
                nxt_len   = L_YELLOW;
            end
            default: begin
                nxt_state = S_RED;
                nxt_len   = L_RED;
            end
        endcase
    end

    // Priority: night > phase advance > pedestrian service > decrement.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ped_d   = ped_q | bus.i_ped_req;
        ack_d   = 1'b0;
        start_d = 1'b0;
        if (bus.i_night) begin
            state_d = (state_q == S_NIGHT_ON) ? S_NIGHT_OFF : S_NIGHT_ON;
            rem_d   = 7'd0;
            ped_d   = 1'b0;
        end else begin
            unique case (state_q)
                S_NIGHT_ON, S_NIGHT_OFF: begin
                    state_d = S_RED;
                    rem_d   = L_RED;
                    start_d = 1'b1;
                end
                S_RED, S_GREEN, S_YELLOW: begin
                    if (bus.i_en) begin
                        if (rem_q <= 7'd1) begin
                            state_d = nxt_state;
                            rem_d   = nxt_len;
                            start_d = 1'b1;
                        end else if (state_q == S_GREEN && ped_q) begin
                            ack_d = 1'b1;
                            ped_d = 1'b0;
                            rem_d = (rem_q > L_PED) ? L_PED : rem_q - 7'd1;
                        end else begin
                            rem_d = rem_q - 7'd1;
                        end
                    end
                end
                default: begin
                    state_d = S_RED;
                    rem_d   = L_RED;
                    ped_d   = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        phase_d = 2'b01;
        unique case (state_d)
            S_RED:       phase_d = 2'b01;
            S_GREEN:     phase_d = 2'b11;
            S_YELLOW:    phase_d = 2'b10;
            S_NIGHT_ON:  phase_d = 2'b10;
            S_NIGHT_OFF: phase_d = 2'b00;
            default:     phase_d = 2'b01;
        endcase
        tens_d = 4'(rem_d / 7'd10);
        ones_d = 4'(rem_d % 7'd10);
    end

    assign bus.o_phase       = phase_q;
    assign bus.o_tens        = tens_q;
    assign bus.o_ones        = ones_q;
    assign bus.o_ped_ack     = ack_q;
    assign bus.o_phase_start = start_q;

endmodule
